// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage RAW detection, redirect flush sequencing and saturating stall/flush counters.
// Optional HAZARD_FWD_EN: load-use-only stalls plus registered forwarding selects.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [5:0]       id_rs,
    input  logic [5:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_regwrt,
    input  logic             ex_memrd,
    input  logic [5:0]       ex_rd,
    input  logic             mem_regwrt,
    input  logic [5:0]       mem_rd,
    input  logic             ex_redirect,
    input  logic             ext_stall,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             busy,
`ifdef HAZARD_FWD_EN
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
`endif
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic {RUN, FLUSH} state_t;
    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       chk_rs, chk_rt, ex_rs, ex_rt, mem_rs, mem_rt, raw, flushing, stall_inc;

    assign chk_rs = id_valid && id_use_rs;
    assign chk_rt = id_valid && id_use_rt;
    assign ex_rs  = chk_rs && ex_regwrt && ex_rd == id_rs && id_rs != 6'd0;
    assign ex_rt  = chk_rt && ex_regwrt && ex_rd == id_rt && id_rt != 6'd0;
    assign mem_rs = chk_rs && mem_regwrt && mem_rd == id_rs && id_rs != 6'd0;
    assign mem_rt = chk_rt && mem_regwrt && mem_rd == id_rt && id_rt != 6'd0;
`ifdef HAZARD_FWD_EN
    assign raw = ex_memrd && (ex_rs || ex_rt);
`else
    assign raw = ex_rs || ex_rt || mem_rs || mem_rt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt holds the FLUSH cycles still owed after the current one, so the
    // redirect cycle plus FLUSH spans exactly FLUSH_CYCLES bubbles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ex_redirect) begin
            state_nxt = FLUSH_CYCLES > 1 ? FLUSH : RUN;
            cnt_nxt   = RELOAD;
        end else if (state == FLUSH && !ext_stall) begin
            state_nxt = cnt <= 3'd1 ? RUN : FLUSH;
            cnt_nxt   = cnt <= 3'd1 ? 3'd0 : cnt - 3'd1;
        end
    end

    always_comb begin
        flushing    = state == FLUSH || ex_redirect;
        ifid_flush  = rst_n && flushing;
        idex_bubble = rst_n && (flushing || (!ext_stall && raw));
        pc_hold     = rst_n && !ex_redirect && (ext_stall || (state == RUN && raw));
        ifid_hold   = rst_n && !flushing && (ext_stall || raw);
        stall_inc   = state == RUN && !ex_redirect && !ext_stall && raw;
        busy        = state == FLUSH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (ex_redirect && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

`ifdef HAZARD_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else if (idex_bubble) begin
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else if (!ext_stall) begin
            fwd_a_sel <= ex_rs ? 2'b01 : mem_rs ? 2'b10 : 2'b00;
            fwd_b_sel <= ex_rt ? 2'b01 : mem_rt ? 2'b10 : 2'b00;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenario tasks for hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4).
module tb_hazard_ctrl;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
    logic [1:0] fwd_a_sel, fwd_b_sel;
`else
    localparam bit FWD = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic id_valid, id_use_rs, id_use_rt, ex_regwrt, ex_memrd, mem_regwrt, ex_redirect, ext_stall;
    logic [5:0] id_rs, id_rt, ex_rd, mem_rd;
    logic pc_hold, ifid_hold, ifid_flush, idex_bubble, busy;
    logic [3:0] stall_cnt, flush_cnt;
    int vec = 0, errs = 0, exp_stall = 0, exp_flush = 0;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_regwrt(ex_regwrt), .ex_memrd(ex_memrd),
        .ex_rd(ex_rd), .mem_regwrt(mem_regwrt), .mem_rd(mem_rd), .ex_redirect(ex_redirect),
        .ext_stall(ext_stall), .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .busy(busy),
`ifdef HAZARD_FWD_EN
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`endif
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle;
        {id_valid, id_use_rs, id_use_rt, ex_regwrt, ex_memrd, mem_regwrt, ex_redirect, ext_stall} = '0;
        {id_rs, id_rt, ex_rd, mem_rd} = '0;
    endtask

    task automatic load_use(input logic [5:0] r);
        ex_memrd = 1; ex_regwrt = 1; ex_rd = r; id_valid = 1; id_rs = r; id_use_rs = 1;
    endtask

    task automatic test_reset;
        idle();
        rst_n = 0; load_use(6'd5); ex_redirect = 1; ext_stall = 1;
        #1;
        vec++; if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, busy} !== 5'b0) begin errs++; $display("FAIL reset_outs got %b want 00000", {pc_hold, ifid_hold, ifid_flush, idex_bubble, busy}); end
        repeat (2) @(posedge clk);
        #1;
        vec++; if ({pc_hold, ifid_flush, idex_bubble, busy} !== 4'b0) begin errs++; $display("FAIL reset_held got %b want 0000", {pc_hold, ifid_flush, idex_bubble, busy}); end
        vec++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin errs++; $display("FAIL reset_cnts got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`ifdef HAZARD_FWD_EN
        vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin errs++; $display("FAIL reset_fwd got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
`endif
        @(negedge clk); idle(); rst_n = 1;
    endtask

    task automatic test_load_use;
        @(negedge clk); idle(); load_use(6'd5);
        #1;
        vec++; if ({pc_hold, ifid_hold, idex_bubble} !== 3'b111) begin errs++; $display("FAIL lu_stall got %b want 111", {pc_hold, ifid_hold, idex_bubble}); end
        vec++; if (stall_cnt !== 4'(exp_stall)) begin errs++; $display("FAIL lu_cnt_before got %0d want %0d", stall_cnt, exp_stall); end
        exp_stall++;
        @(negedge clk); ex_memrd = 0; ex_regwrt = 0; ex_rd = 0; mem_regwrt = 1; mem_rd = 6'd5;
        #1;
        vec++; if (stall_cnt !== 4'(exp_stall)) begin errs++; $display("FAIL lu_cnt_after got %0d want %0d", stall_cnt, exp_stall); end
        vec++; if ({pc_hold, ifid_hold, idex_bubble} !== (FWD ? 3'b000 : 3'b111)) begin errs++; $display("FAIL lu_second got %b want %b", {pc_hold, ifid_hold, idex_bubble}, FWD ? 3'b000 : 3'b111); end
        exp_stall += FWD ? 0 : 1;
`ifdef HAZARD_FWD_EN
        vec++; if (fwd_a_sel !== 2'b00) begin errs++; $display("FAIL lu_fwd_bubble got %b want 00", fwd_a_sel); end
`endif
        @(negedge clk); idle();
        #1;
        vec++; if (pc_hold !== 1'b0 || stall_cnt !== 4'(exp_stall)) begin errs++; $display("FAIL lu_done got %b/%0d want 0/%0d", pc_hold, stall_cnt, exp_stall); end
`ifdef HAZARD_FWD_EN
        vec++; if (fwd_a_sel !== 2'b10) begin errs++; $display("FAIL lu_fwd_mem got %b want 10", fwd_a_sel); end
`endif
    endtask

    task automatic test_mem_raw;
        @(negedge clk); idle(); id_valid = 1; id_rt = 6'd7; id_use_rt = 1; mem_regwrt = 1; mem_rd = 6'd7;
        #1;
        vec++; if ({pc_hold, ifid_hold, idex_bubble} !== (FWD ? 3'b000 : 3'b111)) begin errs++; $display("FAIL mem_raw got %b want %b", {pc_hold, ifid_hold, idex_bubble}, FWD ? 3'b000 : 3'b111); end
        exp_stall += FWD ? 0 : 1;
        @(negedge clk); idle();
        #1;
        vec++; if (pc_hold !== 1'b0 || stall_cnt !== 4'(exp_stall)) begin errs++; $display("FAIL mem_raw_done got %b/%0d want 0/%0d", pc_hold, stall_cnt, exp_stall); end
`ifdef HAZARD_FWD_EN
        vec++; if (fwd_b_sel !== 2'b10) begin errs++; $display("FAIL mem_raw_fwd got %b want 10", fwd_b_sel); end
`endif
    endtask

    task automatic test_ex_raw;
        @(negedge clk); idle(); id_valid = 1; id_rs = 6'd3; id_use_rs = 1; ex_regwrt = 1; ex_rd = 6'd3;
        mem_regwrt = 1; mem_rd = 6'd3;
        #1;
        vec++; if (pc_hold !== (FWD ? 1'b0 : 1'b1)) begin errs++; $display("FAIL ex_raw got %b want %b", pc_hold, FWD ? 1'b0 : 1'b1); end
        exp_stall += FWD ? 0 : 1;
        @(negedge clk); idle();
        #1;
        vec++; if (stall_cnt !== 4'(exp_stall)) begin errs++; $display("FAIL ex_raw_cnt got %0d want %0d", stall_cnt, exp_stall); end
`ifdef HAZARD_FWD_EN
        vec++; if (fwd_a_sel !== 2'b01) begin errs++; $display("FAIL ex_raw_fwd got %b want 01", fwd_a_sel); end
`endif
    endtask

    task automatic test_reg0;
        @(negedge clk); idle(); load_use(6'd0); mem_regwrt = 1; id_use_rt = 1;
        #1;
        vec++; if ({pc_hold, ifid_hold, idex_bubble} !== 3'b000) begin errs++; $display("FAIL reg0 got %b want 000", {pc_hold, ifid_hold, idex_bubble}); end
        @(negedge clk); idle(); load_use(6'd9); id_use_rs = 0;
        #1;
        vec++; if ({pc_hold, idex_bubble} !== 2'b00) begin errs++; $display("FAIL unused_src got %b want 00", {pc_hold, idex_bubble}); end
`ifdef HAZARD_FWD_EN
        vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin errs++; $display("FAIL reg0_fwd got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
`endif
        @(negedge clk); idle(); load_use(6'd9); id_valid = 0;
        #1;
        vec++; if (pc_hold !== 1'b0 || stall_cnt !== 4'(exp_stall)) begin errs++; $display("FAIL invalid_id got %b/%0d want 0/%0d", pc_hold, stall_cnt, exp_stall); end
    endtask

    task automatic test_ext_stall;
        @(negedge clk); idle(); ext_stall = 1; load_use(6'd4);
        #1;
        vec++; if ({pc_hold, ifid_hold, idex_bubble, ifid_flush} !== 4'b1100) begin errs++; $display("FAIL ext_stall got %b want 1100", {pc_hold, ifid_hold, idex_bubble, ifid_flush}); end
        @(negedge clk); idle();
        #1;
        vec++; if (stall_cnt !== 4'(exp_stall)) begin errs++; $display("FAIL ext_stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_redirect;
        @(negedge clk); idle(); ex_redirect = 1;
        #1;
        vec++; if ({ifid_flush, idex_bubble, pc_hold, busy} !== 4'b1100) begin errs++; $display("FAIL redir_c0 got %b want 1100", {ifid_flush, idex_bubble, pc_hold, busy}); end
        exp_flush++;
        @(negedge clk); ex_redirect = 0;
        #1;
        vec++; if ({ifid_flush, idex_bubble, busy} !== 3'b111) begin errs++; $display("FAIL redir_c1 got %b want 111", {ifid_flush, idex_bubble, busy}); end
        vec++; if (flush_cnt !== 4'(exp_flush)) begin errs++; $display("FAIL redir_cnt got %0d want %0d", flush_cnt, exp_flush); end
        @(negedge clk);
        #1;
        vec++; if ({ifid_flush, idex_bubble, busy} !== 3'b000) begin errs++; $display("FAIL redir_end got %b want 000", {ifid_flush, idex_bubble, busy}); end
        @(negedge clk); ex_redirect = 1; exp_flush++;
        @(negedge clk);
        #1;
        vec++; if ({ifid_flush, busy} !== 2'b11) begin errs++; $display("FAIL redir2_c1 got %b want 11", {ifid_flush, busy}); end
        exp_flush++;
        @(negedge clk); ex_redirect = 0; load_use(6'd6);
        #1;
        vec++; if ({ifid_flush, idex_bubble, busy, pc_hold, ifid_hold} !== 5'b11100) begin errs++; $display("FAIL redir2_ext got %b want 11100", {ifid_flush, idex_bubble, busy, pc_hold, ifid_hold}); end
        vec++; if (flush_cnt !== 4'(exp_flush)) begin errs++; $display("FAIL redir2_cnt got %0d want %0d", flush_cnt, exp_flush); end
        @(negedge clk); idle();
        #1;
        vec++; if ({ifid_flush, busy} !== 2'b00 || stall_cnt !== 4'(exp_stall)) begin errs++; $display("FAIL redir2_end got %b/%0d want 00/%0d", {ifid_flush, busy}, stall_cnt, exp_stall); end
        @(negedge clk); ex_redirect = 1; exp_flush++;
        @(negedge clk); ex_redirect = 0; ext_stall = 1;
        @(negedge clk); ext_stall = 0;
        #1;
        vec++; if ({ifid_flush, idex_bubble, busy} !== 3'b111) begin errs++; $display("FAIL flush_frozen got %b want 111", {ifid_flush, idex_bubble, busy}); end
        @(negedge clk);
        #1;
        vec++; if ({ifid_flush, busy} !== 2'b00) begin errs++; $display("FAIL flush_frozen_end got %b want 00", {ifid_flush, busy}); end
    endtask

    task automatic test_priority;
        @(negedge clk); idle(); ex_redirect = 1; ext_stall = 1; load_use(6'd5);
        #1;
        vec++; if ({ifid_flush, idex_bubble, pc_hold, ifid_hold} !== 4'b1100) begin errs++; $display("FAIL prio got %b want 1100", {ifid_flush, idex_bubble, pc_hold, ifid_hold}); end
        exp_flush++;
        @(negedge clk); idle();
        #1;
        vec++; if (stall_cnt !== 4'(exp_stall) || flush_cnt !== 4'(exp_flush)) begin errs++; $display("FAIL prio_cnts got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        @(negedge clk); idle(); load_use(6'd8);
        @(negedge clk);
        #1;
        vec++; if (stall_cnt !== 4'(exp_stall + 1)) begin errs++; $display("FAIL sat_step got %0d want %0d", stall_cnt, exp_stall + 1); end
        repeat (16) @(negedge clk);
        idle();
        #1;
        vec++; if (stall_cnt !== 4'd15) begin errs++; $display("FAIL sat_hold got %0d want 15", stall_cnt); end
        vec++; if (flush_cnt !== 4'(exp_flush)) begin errs++; $display("FAIL sat_flush got %0d want %0d", flush_cnt, exp_flush); end
    endtask

    task automatic test_reset_mid_flush;
        @(negedge clk); idle(); ex_redirect = 1;
        @(negedge clk); ex_redirect = 0;
        #1;
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy got %b want 1", busy); end
        #1 rst_n = 0;
        #1;
        vec++; if ({ifid_flush, idex_bubble, pc_hold, busy} !== 4'b0) begin errs++; $display("FAIL mid_rst got %b want 0000", {ifid_flush, idex_bubble, pc_hold, busy}); end
        vec++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin errs++; $display("FAIL mid_rst_cnts got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        ex_redirect = 1;
        #1;
        vec++; if (ifid_flush !== 1'b0) begin errs++; $display("FAIL mid_rst_gate got %b want 0", ifid_flush); end
        @(negedge clk); idle(); rst_n = 1;
        @(negedge clk);
        #1;
        vec++; if ({ifid_flush, idex_bubble, busy} !== 3'b000) begin errs++; $display("FAIL mid_rst_residual got %b want 000", {ifid_flush, idex_bubble, busy}); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_raw();
        test_ex_raw();
        test_reg0();
        test_ext_stall();
        test_redirect();
        test_priority();
        test_saturation();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
